// File: rtl/cpu_hazard_pkg.sv
// cpu_hazard_pkg: shared types and helpers for the GRF hazard controller
package cpu_hazard_pkg;
  localparam int AW = 5;
  localparam int TW = 2;
  localparam logic [TW-1:0] TNEW_LINK = 2'd0;
  localparam logic [TW-1:0] TNEW_ALU  = 2'd1;
  localparam logic [TW-1:0] TNEW_LOAD = 2'd2;
  typedef enum logic [1:0] {FWD_GRF = 2'd0, FWD_E = 2'd1, FWD_M = 2'd2} fwd_sel_e;
  typedef struct packed {
    logic [AW-1:0] dst;
    logic [TW-1:0] tnew;
  } stage_ent_t;
  function automatic logic [TW-1:0] sat_dec(input logic [TW-1:0] x);
    return x != '0 ? TW'(x - 1'b1) : '0;
  endfunction
  // $0 is never a real producer, so it can never match a source
  function automatic logic src_match(input logic use_s, input logic [AW-1:0] s, input stage_ent_t x);
    return use_s && s != '0 && x.dst == s;
  endfunction
endpackage

// File: rtl/hazard_stage_reg.sv
// hazard_stage_reg: one pipeline entry {dst, tnew} with bubble insert and saturating tnew decrement
module hazard_stage_reg
  import cpu_hazard_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          bubble_i,
  input  logic          dec_i,
  input  logic [AW-1:0] dst_i,
  input  logic [TW-1:0] tnew_i,
  output logic [AW-1:0] dst_o,
  output logic [TW-1:0] tnew_o
);
  stage_ent_t ent_q, ent_d;
  always_comb ent_d = bubble_i ? '0 : stage_ent_t'{dst: dst_i, tnew: dec_i ? sat_dec(tnew_i) : tnew_i};
  always_ff @(posedge clk) ent_q <= reset ? '0 : ent_d;
  assign dst_o  = ent_q.dst;
  assign tnew_o = ent_q.tnew;
endmodule

// File: rtl/grf_hazard_ctrl.sv
// grf_hazard_ctrl: D-stage stall/forward control from E/M/W destination tracking
// HAZARD_FWD_EN enables Tnew/Tuse stalling and E/M forward selects.
module grf_hazard_ctrl
  import cpu_hazard_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          d_valid,
  input  logic [AW-1:0] d_rs,
  input  logic [AW-1:0] d_rt,
  input  logic          d_use_rs,
  input  logic          d_use_rt,
  input  logic [TW-1:0] d_tuse_rs,
  input  logic [TW-1:0] d_tuse_rt,
  input  logic [AW-1:0] d_dst,
  input  logic [TW-1:0] d_tnew,
  output logic          stall,
  output logic [1:0]    fwd_rs_sel,
  output logic [1:0]    fwd_rt_sel,
  output logic [AW-1:0] w_dst
);
  stage_ent_t e, m;
  logic [TW-1:0] w_tnew;
  logic stall_rs, stall_rt, unused;
  hazard_stage_reg u_e (.clk, .reset, .bubble_i(~d_valid | stall), .dec_i(1'b0),
    .dst_i(d_dst), .tnew_i(d_tnew), .dst_o(e.dst), .tnew_o(e.tnew));
  hazard_stage_reg u_m (.clk, .reset, .bubble_i(1'b0), .dec_i(1'b1),
    .dst_i(e.dst), .tnew_i(e.tnew), .dst_o(m.dst), .tnew_o(m.tnew));
  hazard_stage_reg u_w (.clk, .reset, .bubble_i(1'b0), .dec_i(1'b1),
    .dst_i(m.dst), .tnew_i(m.tnew), .dst_o(w_dst), .tnew_o(w_tnew));
`ifdef HAZARD_FWD_EN
  function automatic logic src_stall(input logic use_s, input logic [AW-1:0] s, input logic [TW-1:0] tuse,
                                     input stage_ent_t x, input stage_ent_t y);
    return (src_match(use_s, s, x) && x.tnew > tuse) || (src_match(use_s, s, y) && y.tnew > tuse);
  endfunction
  // youngest producer wins: an E match that is not ready blocks an older ready M value
  function automatic fwd_sel_e src_fwd(input logic use_s, input logic [AW-1:0] s,
                                       input stage_ent_t x, input stage_ent_t y);
    return src_match(use_s, s, x) ? (x.tnew == '0 ? FWD_E : FWD_GRF)
         : (src_match(use_s, s, y) && y.tnew == '0) ? FWD_M : FWD_GRF;
  endfunction
  assign stall_rs   = src_stall(d_use_rs, d_rs, d_tuse_rs, e, m);
  assign stall_rt   = src_stall(d_use_rt, d_rt, d_tuse_rt, e, m);
  assign fwd_rs_sel = src_fwd(d_use_rs, d_rs, e, m);
  assign fwd_rt_sel = src_fwd(d_use_rt, d_rt, e, m);
  assign unused     = ^w_tnew;
`else
  function automatic logic src_stall(input logic use_s, input logic [AW-1:0] s,
                                     input stage_ent_t x, input stage_ent_t y);
    return src_match(use_s, s, x) || src_match(use_s, s, y);
  endfunction
  assign stall_rs   = src_stall(d_use_rs, d_rs, e, m);
  assign stall_rt   = src_stall(d_use_rt, d_rt, e, m);
  assign fwd_rs_sel = FWD_GRF;
  assign fwd_rt_sel = FWD_GRF;
  assign unused     = ^{w_tnew, d_tuse_rs, d_tuse_rt};
`endif
  assign stall = d_valid & (stall_rs | stall_rt);
endmodule

// File: tb/tb_grf_hazard_ctrl.sv
// tb_grf_hazard_ctrl: directed self-checking bench for grf_hazard_ctrl (either HAZARD_FWD_EN setting)
module tb_grf_hazard_ctrl;
  logic clk = 1'b0;
  logic reset, d_valid, d_use_rs, d_use_rt, stall;
  logic [4:0] d_rs, d_rt, d_dst, w_dst;
  logic [1:0] d_tuse_rs, d_tuse_rt, d_tnew, fwd_rs_sel, fwd_rt_sel;
  int passed = 0, total = 0;
  always #5 clk = ~clk;
  grf_hazard_ctrl dut (.clk(clk), .reset(reset), .d_valid(d_valid), .d_rs(d_rs), .d_rt(d_rt),
    .d_use_rs(d_use_rs), .d_use_rt(d_use_rt), .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt),
    .d_dst(d_dst), .d_tnew(d_tnew), .stall(stall), .fwd_rs_sel(fwd_rs_sel),
    .fwd_rt_sel(fwd_rt_sel), .w_dst(w_dst));
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    d_valid = 0; d_rs = 0; d_rt = 0; d_use_rs = 0; d_use_rt = 0;
    d_tuse_rs = 0; d_tuse_rt = 0; d_dst = 0; d_tnew = 0;
  endtask
  task automatic issue(input logic [4:0] dst, input logic [1:0] tnew);
    idle();
    d_valid = 1; d_dst = dst; d_tnew = tnew;
  endtask
  task automatic reader(input logic [4:0] rs, input logic [4:0] rt, input logic urs, input logic urt,
                        input logic [1:0] trs, input logic [1:0] trt);
    idle();
    d_valid = 1; d_rs = rs; d_rt = rt; d_use_rs = urs; d_use_rt = urt; d_tuse_rs = trs; d_tuse_rt = trt;
  endtask
  initial begin
    idle();
    reset = 1;
    tick(); tick();
    reset = 0;
    #1;
    chk("rst_stall", stall, 0);
    chk("rst_fwd_rs", fwd_rs_sel, 0);
    chk("rst_fwd_rt", fwd_rt_sel, 0);
    chk("rst_w_dst", w_dst, 0);
    reader(1, 2, 1, 1, 0, 0);
    #1 chk("rst_reader_stall", stall, 0);
    // $0 as destination in E, readers of $0, then dst 5 through to W
    issue(0, 1);
    tick();
    issue(5, 1);
    d_use_rs = 1; d_use_rt = 1;
    #1;
    chk("zero_stall", stall, 0);
    chk("zero_fwd_rs", fwd_rs_sel, 0);
    chk("zero_fwd_rt", fwd_rt_sel, 0);
    tick(); idle();
    #1 chk("w5_c1", w_dst, 0);
    tick(); chk("w5_c2", w_dst, 0);
    tick(); chk("w5_c3", w_dst, 5);
    tick(); chk("w5_c4", w_dst, 0);
    tick(); tick();
    // ALU dst 3 followed by a reader of rt=3
    issue(3, 1);
    tick();
    reader(7, 3, 1, 1, 0, 0);
    #1;
    chk("alu3_stall_e", stall, 1);
    chk("alu3_fwd_rt_e", fwd_rt_sel, 0);
    tick();
`ifdef HAZARD_FWD_EN
    chk("alu3_stall_m", stall, 0);
    chk("alu3_fwd_rt_m", fwd_rt_sel, 2);
`else
    chk("alu3_stall_m", stall, 1);
    chk("alu3_fwd_rt_m", fwd_rt_sel, 0);
`endif
    tick();
    chk("alu3_stall_w", stall, 0);
    chk("alu3_w_dst", w_dst, 3);
    idle(); tick(); tick(); tick();
    // invalid D never stalls; rs==rt resolves identically; unused sources ignored
    issue(6, 1);
    tick();
    idle(); d_rs = 6; d_use_rs = 1;
    #1 chk("inval_stall", stall, 0);
    reader(6, 6, 1, 1, 1, 1);
    #1;
`ifdef HAZARD_FWD_EN
    chk("same_stall", stall, 0);
`else
    chk("same_stall", stall, 1);
`endif
    chk("same_fwd_rs", fwd_rs_sel, 0);
    chk("same_fwd_rt", fwd_rt_sel, 0);
    reader(6, 6, 0, 0, 0, 0);
    #1 chk("nouse_stall", stall, 0);
    idle(); tick(); tick(); tick();
`ifdef HAZARD_FWD_EN
    issue(8, 1);
    tick();
    reader(8, 0, 1, 0, 1, 0);
    #1;
    chk("alu8_stall", stall, 0);
    chk("alu8_fwd_e", fwd_rs_sel, 0);
    tick();
    chk("alu8_fwd_m", fwd_rs_sel, 2);
    chk("alu8_stall_m", stall, 0);
    idle(); tick(); tick(); tick();
    issue(9, 2);
    tick();
    reader(9, 0, 1, 0, 0, 0);
    #1 chk("ld9_stall_1", stall, 1);
    tick();
    chk("ld9_stall_2", stall, 1);
    chk("ld9_fwd_2", fwd_rs_sel, 0);
    tick();
    chk("ld9_stall_3", stall, 0);
    chk("ld9_fwd_3", fwd_rs_sel, 0);
    chk("ld9_w_dst", w_dst, 9);
    idle(); tick(); tick(); tick();
    issue(10, 1);
    tick();
    issue(10, 2);
    tick();
    reader(10, 0, 1, 0, 0, 0);
    #1;
    chk("prio_stall", stall, 1);
    chk("prio_fwd", fwd_rs_sel, 0);
    idle(); tick(); tick(); tick();
`endif
    // load dst 4 in E when reset hits: its write must vanish
    issue(4, 2);
    tick();
    idle(); reset = 1;
    tick();
    reset = 0;
    reader(4, 4, 1, 1, 0, 0);
    #1 chk("rst_mid_stall", stall, 0);
    tick(); idle();
    chk("rst_mid_w1", w_dst, 0);
    tick(); chk("rst_mid_w2", w_dst, 0);
    tick(); chk("rst_mid_w3", w_dst, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
